// File: rtl/conv_layer_batched.sv
// Batched multi-filter convolution layer: P MAC lanes sweep one D x H x W image per filter batch,
// then add bias, rescale, saturate, optionally ReLU, and stream each pixel out over ready/valid.
module conv_layer_batched #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC       = 8,
    parameter int D          = 6,
    parameter int H          = 14,
    parameter int W          = 14,
    parameter int F          = 5,
    parameter int S          = 1,
    parameter int K          = 16,
    parameter int P          = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  relu_en,
    input  logic [D*H*W*DATA_WIDTH-1:0]           image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]         filters,
    input  logic [K*DATA_WIDTH-1:0]               biases,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [P*DATA_WIDTH-1:0]               out_data,
    output logic [P-1:0]                          out_mask,
    output logic [$clog2((K+P-1)/P):0]            out_group,
    output logic [$clog2((H-F)/S+1):0]            out_row,
    output logic [$clog2((W-F)/S+1):0]            out_col
);

    localparam int NG  = (K + P - 1) / P;
    localparam int OH  = (H - F) / S + 1;
    localparam int OW  = (W - F) / S + 1;
    localparam int GW  = $clog2(NG) + 1;
    localparam int RW  = $clog2(OH) + 1;
    localparam int CW  = $clog2(OW) + 1;
    localparam int DCW = $clog2(D) + 1;
    localparam int FCW = $clog2(F) + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, MAC, NORM, OUT, DONE} state_t;

    state_t state, state_next;

    logic [GW-1:0]  group;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [DCW-1:0] d_cnt;
    logic [FCW-1:0] fy_cnt, fx_cnt;
    logic           relu_q;
    logic           last_tap, last_col, last_row, last_group, last_pixel;

    logic signed [ACC_WIDTH-1:0]    acc      [P];
    logic signed [ACC_WIDTH-1:0]    acc_next [P];
    logic signed [ACC_WIDTH-1:0]    biased   [P];
    logic signed [ACC_WIDTH-1:0]    scaled   [P];
    logic signed [2*DATA_WIDTH-1:0] prod     [P];
    logic signed [DATA_WIDTH-1:0]   weight   [P];
    logic signed [DATA_WIDTH-1:0]   bias_w   [P];
    logic signed [DATA_WIDTH-1:0]   res      [P];
    logic signed [DATA_WIDTH-1:0]   pixel;
    int                             lane_k   [P];
    int                             img_shift;
    logic [P*DATA_WIDTH-1:0]        norm_data;
    logic [P-1:0]                   lane_mask;

    assign last_tap   = (d_cnt == DCW'(D-1)) && (fy_cnt == FCW'(F-1)) && (fx_cnt == FCW'(F-1));
    assign last_col   = (col == CW'(OW-1));
    assign last_row   = (row == RW'(OH-1));
    assign last_group = (group == GW'(NG-1));
    assign last_pixel = last_col && last_row && last_group;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: if (start) state_next = MAC;
            MAC: begin
                busy = 1'b1;
                if (last_tap) state_next = NORM;
            end
            NORM: begin
                busy       = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = last_pixel ? DONE : MAC;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Lanes past K in the final batch read no filter or bias word and are forced to zero.
    always_comb begin
        img_shift = (D*H*W - 1 - ((int'(d_cnt)*H + int'(row)*S + int'(fy_cnt))*W
                                  + int'(col)*S + int'(fx_cnt))) * DATA_WIDTH;
        pixel     = DATA_WIDTH'(image >> img_shift);
        norm_data = '0;
        lane_mask = '0;
        for (int j = 0; j < P; j++) begin
            lane_k[j] = int'(group)*P + j;
            weight[j] = '0;
            bias_w[j] = '0;
            if (lane_k[j] < K) begin
                lane_mask[P-1-j] = 1'b1;
                weight[j] = DATA_WIDTH'(filters >> ((K*D*F*F - 1
                            - (((lane_k[j]*D + int'(d_cnt))*F + int'(fy_cnt))*F + int'(fx_cnt)))
                            * DATA_WIDTH));
                bias_w[j] = DATA_WIDTH'(biases >> ((K - 1 - lane_k[j]) * DATA_WIDTH));
            end
            prod[j]     = pixel * weight[j];
            acc_next[j] = acc[j] + ACC_WIDTH'(prod[j]);
            biased[j]   = acc[j] + (ACC_WIDTH'(bias_w[j]) <<< FRAC);
            scaled[j]   = biased[j] >>> FRAC;
            if (scaled[j] > SAT_MAX)      res[j] = SAT_MAX[DATA_WIDTH-1:0];
            else if (scaled[j] < SAT_MIN) res[j] = SAT_MIN[DATA_WIDTH-1:0];
            else                          res[j] = scaled[j][DATA_WIDTH-1:0];
            if ((relu_q && res[j][DATA_WIDTH-1]) || (lane_k[j] >= K)) res[j] = '0;
            norm_data[(P-1-j)*DATA_WIDTH +: DATA_WIDTH] = res[j];
        end
    end

    // Tap counters wrap to zero after the last tap, so each pixel starts clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            group     <= '0;
            row       <= '0;
            col       <= '0;
            d_cnt     <= '0;
            fy_cnt    <= '0;
            fx_cnt    <= '0;
            relu_q    <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_group <= '0;
            out_row   <= '0;
            out_col   <= '0;
            for (int j = 0; j < P; j++) acc[j] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    group  <= '0;
                    row    <= '0;
                    col    <= '0;
                    d_cnt  <= '0;
                    fy_cnt <= '0;
                    fx_cnt <= '0;
                    relu_q <= relu_en;
                    for (int j = 0; j < P; j++) acc[j] <= '0;
                end
                MAC: begin
                    for (int j = 0; j < P; j++) acc[j] <= acc_next[j];
                    if (fx_cnt == FCW'(F-1)) begin
                        fx_cnt <= '0;
                        if (fy_cnt == FCW'(F-1)) begin
                            fy_cnt <= '0;
                            d_cnt  <= (d_cnt == DCW'(D-1)) ? '0 : d_cnt + DCW'(1);
                        end else begin
                            fy_cnt <= fy_cnt + FCW'(1);
                        end
                    end else begin
                        fx_cnt <= fx_cnt + FCW'(1);
                    end
                end
                NORM: begin
                    out_data  <= norm_data;
                    out_mask  <= lane_mask;
                    out_group <= group;
                    out_row   <= row;
                    out_col   <= col;
                end
                OUT: if (out_ready) begin
                    for (int j = 0; j < P; j++) acc[j] <= '0;
                    if (last_col) begin
                        col <= '0;
                        if (last_row) begin
                            row   <= '0;
                            group <= last_group ? '0 : group + GW'(1);
                        end else begin
                            row <= row + RW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_batched.sv
// Directed self-checking bench: small 3-filter/2-lane layer, an 8-bit saturation layer and a
// 1x1 FRAC=4 rescale layer, all with hand-computed expected words.
module tb_conv_layer_batched;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: D=1 H=4 W=4 F=3 K=3 P=2, 16-bit, FRAC=0 -> 2 groups of 2x2 pixels
    logic          a_start, a_relu, a_busy, a_done, a_valid, a_ready;
    logic [255:0]  a_image;
    logic [431:0]  a_filters;
    logic [47:0]   a_biases;
    logic [31:0]   a_data;
    logic [1:0]    a_mask, a_group, a_row, a_col;

    conv_layer_batched #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC(0), .D(1), .H(4), .W(4),
                         .F(3), .S(1), .K(3), .P(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .relu_en(a_relu),
        .image(a_image), .filters(a_filters), .biases(a_biases),
        .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(a_ready),
        .out_data(a_data), .out_mask(a_mask), .out_group(a_group), .out_row(a_row), .out_col(a_col));

    // Instance B: 8-bit words, one 3x3 window, one filter
    logic          b_start, b_relu, b_busy, b_done, b_valid;
    logic [71:0]   b_image, b_filters;
    logic [7:0]    b_biases, b_data;
    logic [0:0]    b_mask, b_group, b_row, b_col;

    conv_layer_batched #(.DATA_WIDTH(8), .ACC_WIDTH(24), .FRAC(0), .D(1), .H(3), .W(3),
                         .F(3), .S(1), .K(1), .P(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .relu_en(b_relu),
        .image(b_image), .filters(b_filters), .biases(b_biases),
        .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(1'b1),
        .out_data(b_data), .out_mask(b_mask), .out_group(b_group), .out_row(b_row), .out_col(b_col));

    // Instance C: 1x1 image and filter, FRAC=4
    logic          c_start, c_busy, c_done, c_valid;
    logic [15:0]   c_image, c_filters, c_biases, c_data;
    logic [0:0]    c_mask, c_group, c_row, c_col;

    conv_layer_batched #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC(4), .D(1), .H(1), .W(1),
                         .F(1), .S(1), .K(1), .P(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(c_start), .relu_en(1'b0),
        .image(c_image), .filters(c_filters), .biases(c_biases),
        .busy(c_busy), .done(c_done), .out_valid(c_valid), .out_ready(1'b1),
        .out_data(c_data), .out_mask(c_mask), .out_group(c_group), .out_row(c_row), .out_col(c_col));

    logic [31:0] cap_data  [8];
    logic [1:0]  cap_mask  [8];
    logic [5:0]  cap_pos   [8];
    int          cap_n, lat_first, lat_done;
    logic        busy_at_start, busy_at_done;
    logic [7:0]  b_got;
    logic [15:0] c_got;
    logic        b_timeout, c_timeout;

    task automatic load_a_uniform(input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2);
        for (int i = 0; i < 16; i++) a_image[(15-i)*16 +: 16] = 16'd1;
        for (int t = 0; t < 9; t++) begin
            a_filters[(26-t)*16 +: 16]  = k0;
            a_filters[(17-t)*16 +: 16]  = k1;
            a_filters[(8-t)*16 +: 16]   = k2;
        end
        a_biases = '0;
    endtask

    task automatic run_a(input logic relu, input int spurious_cyc, input logic start_on_done);
        int cyc;
        @(negedge clk);
        a_relu  = relu;
        a_ready = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_relu  = ~relu;
        cap_n = 0; lat_first = -1; lat_done = -1;
        busy_at_start = a_busy; busy_at_done = 1'b1;
        cyc = 0;
        while (lat_done < 0 && cyc < 300) begin
            a_start = (cyc == spurious_cyc);
            if (a_valid && cap_n < 8) begin
                cap_data[cap_n] = a_data;
                cap_mask[cap_n] = a_mask;
                cap_pos[cap_n]  = {a_group, a_row, a_col};
                if (cap_n == 0) lat_first = cyc + 1;
                cap_n++;
            end
            if (a_done) begin
                lat_done     = cyc;
                busy_at_done = a_busy;
                a_start      = start_on_done;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a_start = 1'b0;
    endtask

    task automatic run_b(input logic relu);
        int cyc;
        @(negedge clk);
        b_relu = relu; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0; b_got = '0;
        cyc = 0;
        while (!b_done && cyc < 100) begin
            if (b_valid) b_got = b_data;
            @(posedge clk); #1;
            cyc++;
        end
        b_timeout = !b_done;
        @(posedge clk); #1;
    endtask

    task automatic run_c;
        int cyc;
        @(negedge clk);
        c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0; c_got = '0;
        cyc = 0;
        while (!c_done && cyc < 100) begin
            if (c_valid) c_got = c_data;
            @(posedge clk); #1;
            cyc++;
        end
        c_timeout = !c_done;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_busy !== 1'b0)  begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", a_busy); end
        total++; if (a_done !== 1'b0)  begin bad++; $display("[TB] FAIL reset_done: got %b want 0", a_done); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", a_valid); end
        total++; if (a_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", a_data); end
        total++; if ({a_mask, a_group, a_row, a_col} !== 8'h0)
            begin bad++; $display("[TB] FAIL reset_fields: got %h want 0", {a_mask, a_group, a_row, a_col}); end
        total++; if (b_data !== 8'h0 || c_data !== 16'h0)
            begin bad++; $display("[TB] FAIL reset_bc_data: got %h/%h want 0/0", b_data, c_data); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] exp_d;
        logic [1:0]  exp_m;
        logic [5:0]  exp_p;
        load_a_uniform(16'h0001, 16'hFFFF, 16'h0002);
        run_a(1'b0, 20, 1'b1);
        total++; if (cap_n !== 8) begin bad++; $display("[TB] FAIL basic_count: got %0d want 8", cap_n); end
        for (int i = 0; i < 8; i++) begin
            exp_d = (i < 4) ? {16'd9, 16'hFFF7} : {16'd18, 16'd0};
            exp_m = (i < 4) ? 2'b11 : 2'b10;
            exp_p = {2'(i/4), 2'((i%4)/2), 2'(i%2)};
            total++; if (cap_data[i] !== exp_d)
                begin bad++; $display("[TB] FAIL basic_data[%0d]: got %h want %h", i, cap_data[i], exp_d); end
            total++; if ({cap_mask[i], cap_pos[i]} !== {exp_m, exp_p})
                begin bad++; $display("[TB] FAIL basic_pos[%0d]: got %h want %h", i, {cap_mask[i], cap_pos[i]}, {exp_m, exp_p}); end
        end
        total++; if (lat_first !== 11) begin bad++; $display("[TB] FAIL first_handshake: got %0d want 11", lat_first); end
        total++; if (lat_done !== 88)  begin bad++; $display("[TB] FAIL done_latency: got %0d want 88", lat_done); end
        total++; if (busy_at_start !== 1'b1 || busy_at_done !== 1'b0)
            begin bad++; $display("[TB] FAIL busy_window: got %b%b want 10", busy_at_start, busy_at_done); end
        total++; if (a_done !== 1'b0 || a_busy !== 1'b0)
            begin bad++; $display("[TB] FAIL done_pulse_or_start_on_done: done=%b busy=%b want 0 0", a_done, a_busy); end
    endtask

    task automatic test_relu_bias;
        logic [31:0] exp_d [8];
        exp_d = '{{16'd14, 16'd0}, {16'd14, 16'd0}, {16'd14, 16'd0}, {16'd14, 16'd0},
                  {16'd18, 16'd0}, {16'd18, 16'd0}, {16'd18, 16'd0}, {16'd18, 16'd0}};
        load_a_uniform(16'h0001, 16'hFFFF, 16'h0002);
        a_biases[47:32] = 16'd5;
        run_a(1'b1, -1, 1'b0);
        total++; if (cap_n !== 8 || lat_done !== 88)
            begin bad++; $display("[TB] FAIL relu_job: got words=%0d done_at=%0d want 8 88", cap_n, lat_done); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_data[i] !== exp_d[i])
                begin bad++; $display("[TB] FAIL relu_data[%0d]: got %h want %h", i, cap_data[i], exp_d[i]); end
        end
    endtask

    // Ramp image and sparse filters catch row/column/tap indexing errors.
    task automatic test_back_to_back;
        logic [31:0] exp_d [8];
        exp_d = '{{16'd6, 16'd5}, {16'd7, 16'd6}, {16'd10, 16'd9}, {16'd11, 16'd10},
                  {16'd45, 16'd0}, {16'd54, 16'd0}, {16'd81, 16'd0}, {16'd90, 16'd0}};
        for (int i = 0; i < 16; i++) a_image[(15-i)*16 +: 16] = 16'(i);
        a_filters = '0;
        a_filters[(26-5)*16 +: 16] = 16'd1;
        a_filters[(17-6)*16 +: 16] = 16'd1;
        for (int t = 0; t < 9; t++) a_filters[(8-t)*16 +: 16] = 16'd1;
        a_biases = {16'd0, 16'hFFFD, 16'd0};
        run_a(1'b0, -1, 1'b0);
        total++; if (cap_n !== 8 || lat_done !== 88)
            begin bad++; $display("[TB] FAIL b2b_job: got words=%0d done_at=%0d want 8 88", cap_n, lat_done); end
        for (int i = 0; i < 8; i++) begin
            total++; if (cap_data[i] !== exp_d[i])
                begin bad++; $display("[TB] FAIL b2b_data[%0d]: got %h want %h", i, cap_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        load_a_uniform(16'h0001, 16'hFFFF, 16'h0002);
        @(negedge clk);
        a_ready = 1'b0; a_relu = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 0;
        while (!a_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        total++; if ({a_valid, a_data, a_group, a_row, a_col} !== {1'b1, 16'd9, 16'hFFF7, 6'h0})
            begin bad++; $display("[TB] FAIL bp_first: got %b %h %h want 1 0009fff7 00", a_valid, a_data, {a_group, a_row, a_col}); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if ({a_valid, a_data, a_group, a_row, a_col} !== {1'b1, 16'd9, 16'hFFF7, 6'h0})
                begin bad++; $display("[TB] FAIL bp_hold[%0d]: got %b %h %h want 1 0009fff7 00", i, a_valid, a_data, {a_group, a_row, a_col}); end
        end
        a_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (a_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release: got valid=%b want 0", a_valid); end
        cyc = 0;
        while (!a_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        total++; if ({a_valid, a_group, a_row, a_col} !== {1'b1, 6'b000001} || cyc !== 10)
            begin bad++; $display("[TB] FAIL bp_next: got %b %h after %0d want 1 01 after 10", a_valid, {a_group, a_row, a_col}, cyc); end
        cyc = 0;
        while (!a_done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        total++; if (a_done !== 1'b1) begin bad++; $display("[TB] FAIL bp_done: got %b want 1", a_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        load_a_uniform(16'h0001, 16'hFFFF, 16'h0002);
        @(negedge clk);
        a_relu = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({a_busy, a_valid, a_done} !== 3'b000)
            begin bad++; $display("[TB] FAIL midreset_ctrl: got %b want 000", {a_busy, a_valid, a_done}); end
        total++; if (a_data !== 32'h0) begin bad++; $display("[TB] FAIL midreset_data: got %h want 0", a_data); end
        @(negedge clk);
        reset_n = 1'b1;
        run_a(1'b0, -1, 1'b0);
        total++; if (cap_n !== 8 || lat_done !== 88)
            begin bad++; $display("[TB] FAIL midreset_job: got words=%0d done_at=%0d want 8 88", cap_n, lat_done); end
        total++; if (cap_data[0] !== {16'd9, 16'hFFF7} || cap_data[7] !== {16'd18, 16'd0})
            begin bad++; $display("[TB] FAIL midreset_words: got %h %h want 0009fff7 00120000", cap_data[0], cap_data[7]); end
    endtask

    task automatic test_saturation;
        b_image   = {9{8'd100}};
        b_filters = {9{8'd100}};
        b_biases  = 8'd0;
        run_b(1'b0);
        total++; if (b_timeout || b_got !== 8'h7F)
            begin bad++; $display("[TB] FAIL sat_pos: got %h timeout=%b want 7f", b_got, b_timeout); end
        b_filters = {9{8'h9C}};
        run_b(1'b0);
        total++; if (b_timeout || b_got !== 8'h80)
            begin bad++; $display("[TB] FAIL sat_neg: got %h timeout=%b want 80", b_got, b_timeout); end
        run_b(1'b1);
        total++; if (b_timeout || b_got !== 8'h00)
            begin bad++; $display("[TB] FAIL sat_relu: got %h timeout=%b want 00", b_got, b_timeout); end
    endtask

    task automatic test_frac;
        c_image = 16'h0010; c_filters = 16'h0010; c_biases = 16'h0000;
        run_c;
        total++; if (c_timeout || c_got !== 16'h0010)
            begin bad++; $display("[TB] FAIL frac_plain: got %h want 0010", c_got); end
        c_biases = 16'h0008;
        run_c;
        total++; if (c_timeout || c_got !== 16'h0018)
            begin bad++; $display("[TB] FAIL frac_bias: got %h want 0018", c_got); end
        c_biases = 16'hFFFF;
        run_c;
        total++; if (c_timeout || c_got !== 16'h000F)
            begin bad++; $display("[TB] FAIL frac_negbias: got %h want 000f", c_got); end
        c_image = 16'h0001; c_filters = 16'hFFFF; c_biases = 16'h0000;
        run_c;
        total++; if (c_timeout || c_got !== 16'hFFFF)
            begin bad++; $display("[TB] FAIL frac_arith_shift: got %h want ffff", c_got); end
    endtask

    initial begin
        reset_n = 1'b0;
        a_start = 1'b0; a_relu = 1'b0; a_ready = 1'b1;
        a_image = '0; a_filters = '0; a_biases = '0;
        b_start = 1'b0; b_relu = 1'b0; b_image = '0; b_filters = '0; b_biases = '0;
        c_start = 1'b0; c_image = '0; c_filters = '0; c_biases = '0;
        test_reset;
        test_basic;
        test_relu_bias;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_saturation;
        test_frac;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
